// File: rtl/config_readback_capture_if.sv
// Readback bus between the capture block and the AXI-Lite register file.
//   rd_pop     : register file pops the FIFO head
//   rd_data    : FIFO head word, valid while rd_valid=1
//   rd_valid   : FIFO non-empty
//   fifo_level : words currently stored
// slave = capture block side, master = register file side.
interface config_readback_capture_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = 32
);
  logic                              rd_pop;
  logic [DW-1:0]                     rd_data;
  logic                              rd_valid;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level;

  modport slave  (input  rd_pop, output rd_data, output rd_valid, output fifo_level);
  modport master (output rd_pop, input  rd_data, input  rd_valid, input  fifo_level);
endinterface

// File: rtl/config_readback_capture.sv
// Captures the serial ConfigOut stream of a configuration shift frame, packs
// it LSB-first into 32-bit words and queues them for register-file readback.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   cfg_start    : pulse, new frame (also clears FIFO/flags mid-frame)
//   cfg_clk_rise : pulse per ConfigClk rising edge
//   ConfigOut    : chip serial data, asynchronous
//   rd           : readback bus (pop / head word / valid / level)
//   bit_count    : bits captured in the current frame
//   frame_done   : whole frame captured
//   overflow     : sticky, a completed word was dropped on a full FIFO
module config_readback_capture #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CONFIG_REG_WIDTH   = 5164,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        cfg_start,
  input  logic                        cfg_clk_rise,
  input  logic                        ConfigOut,
  config_readback_capture_if.slave    rd,
  output logic [12:0]                 bit_count,
  output logic                        frame_done,
  output logic                        overflow
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam logic [12:0]   LAST_BIT = 13'(CONFIG_REG_WIDTH-1);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state;

  // ConfigOut synchronizer and matching 2-stage strobe delay
  logic [1:0] co_sync;
  logic [1:0] vld_pipe;
  logic       sample_en, bit_in;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      co_sync  <= '0;
      vld_pipe <= '0;
    end else begin
      co_sync  <= {co_sync[0], ConfigOut};
      // strobes are not cleared by cfg_start: in-flight ones still land
      vld_pipe <= {vld_pipe[0], cfg_clk_rise};
    end
  end

  assign sample_en = vld_pipe[1];
  assign bit_in    = co_sync[1];

  logic [DW-1:0] assembler, word_next;
  logic [4:0]    bit_idx;
  logic          last_bit, take, push, pop_ok, push_ok, drop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [DW-1:0] mem [FIFO_DEPTH];

  assign bit_idx   = bit_count[4:0];
  // assembler bits above bit_idx are always zero, giving zero padding
  assign word_next = assembler | (DW'(bit_in) << bit_idx);
  assign last_bit  = (bit_count == LAST_BIT);
  assign take      = (state == CAPTURE) && sample_en && !cfg_start;
  assign push      = take && ((bit_idx == 5'd31) || last_bit);
  assign pop_ok    = rd.rd_pop && (level != '0);
  // a pop in the same cycle frees the slot the push needs
  assign push_ok   = push && ((level != FULL) || pop_ok);
  assign drop      = push && !push_ok;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state      <= IDLE;
      bit_count  <= '0;
      assembler  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else if (cfg_start) begin
      state      <= CAPTURE;
      bit_count  <= '0;
      assembler  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      if (take) begin
        bit_count <= bit_count + 13'd1;
        assembler <= push ? '0 : word_next;
        if (last_bit) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      if (drop)    overflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // storage needs no reset; the head is masked while empty
  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok && !cfg_start) mem[wr_ptr] <= word_next;
  end

  assign rd.rd_valid   = (level != '0);
  assign rd.rd_data    = rd.rd_valid ? mem[rd_ptr] : '0;
  assign rd.fifo_level = level;
endmodule

// File: tb/tb_config_readback_capture.sv
module tb_config_readback_capture;
  localparam int W     = 5164;
  localparam int DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_clk_rise = 1'b0, config_out = 1'b0;
  logic [12:0] bc_a, bc_b;
  logic fd_a, fd_b, ov_a, ov_b;

  always #5 clk = ~clk;

  config_readback_capture_if #(.FIFO_DEPTH(DEPTH)) rda ();
  config_readback_capture_if #(.FIFO_DEPTH(DEPTH)) rdb ();

  config_readback_capture #(.CONFIG_REG_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .cfg_start(cfg_start),
    .cfg_clk_rise(cfg_clk_rise), .ConfigOut(config_out), .rd(rda),
    .bit_count(bc_a), .frame_done(fd_a), .overflow(ov_a));

  config_readback_capture #(.CONFIG_REG_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut_b (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .cfg_start(cfg_start),
    .cfg_clk_rise(cfg_clk_rise), .ConfigOut(config_out), .rd(rdb),
    .bit_count(bc_b), .frame_done(fd_b), .overflow(ov_b));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model for dut_a: frame bits -> words -> bounded queue
  logic [31:0] mq[$];
  bit          m_active, m_done, m_ovf;
  int          m_bits;
  logic [31:0] m_asm;

  task automatic model_clear(input bit active);
    mq.delete();
    m_bits = 0; m_asm = '0; m_ovf = 0; m_done = 0; m_active = active;
  endtask

  task automatic model_bit(input bit b);
    if (!m_active || m_done) return;
    m_asm[m_bits % 32] = b;
    m_bits++;
    if ((m_bits % 32 == 0) || (m_bits == W)) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(m_asm);
      m_asm = '0;
      if (m_bits == W) m_done = 1;
    end
  endtask

  task automatic model_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    model_clear(1);
  endtask

  // one strobe, then idle cycles with garbage on ConfigOut
  task automatic send_bit(input bit b);
    cfg_clk_rise = 1'b1; config_out = b; tick();
    cfg_clk_rise = 1'b0; config_out = 1'($urandom);
    tick(); tick(); tick();
    model_bit(b);
  endtask

  task automatic pop_a();
    rda.rd_pop = 1'b1; tick(); rda.rd_pop = 1'b0;
    model_pop();
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_valid"}, rda.rd_valid, mq.size() != 0);
    chk({tag, "_data"},  rda.rd_data,  mq.size() != 0 ? mq[0] : 32'h0);
    chk({tag, "_lvl"},   rda.fifo_level, mq.size());
    chk({tag, "_bc"},    bc_a, m_bits);
    chk({tag, "_done"},  fd_a, m_done);
    chk({tag, "_ovf"},   ov_a, m_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit b;
    int nwords;
    rda.rd_pop = 1'b0; rdb.rd_pop = 1'b0;
    model_clear(0);
    tick(); tick();
    check_a("reset");
    chk("reset_b_valid", rdb.rd_valid, 0);
    rst_n = 1'b1; tick();

    // small frame on the 5-bit instance
    start();
    send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("small_data", rdb.rd_data, 32'h1B);
    chk("small_lvl",  rdb.fifo_level, 1);
    chk("small_done", fd_b, 1);
    chk("small_bc",   bc_b, 5);
    send_bit(1);
    chk("small_ignored_bc",  bc_b, 5);
    chk("small_ignored_lvl", rdb.fifo_level, 1);
    for (int i = 0; i < 3; i++) begin
      rdb.rd_pop = 1'b1; tick(); rdb.rd_pop = 1'b0;
      chk("small_pop_lvl",   rdb.fifo_level, 0);
      chk("small_pop_valid", rdb.rd_valid, 0);
    end

    // overflow: 17 words, no pops
    start();
    for (int i = 0; i < 17 * 32; i++) begin
      send_bit(1'($urandom));
      if ((i % 32) == 31) check_a("ovf_fill");
    end
    chk("ovf_lvl",  rda.fifo_level, 16);
    chk("ovf_flag", ov_a, 1);
    for (int i = 0; i < 16; i++) begin
      check_a("ovf_drain");
      pop_a();
    end
    check_a("ovf_empty");
    pop_a();
    chk("empty_pop_lvl", rda.fifo_level, 0);

    // push and pop in the same cycle on a full FIFO
    start();
    for (int i = 0; i < 16 * 32 + 31; i++) send_bit(1'($urandom));
    chk("simul_pre_lvl", rda.fifo_level, 16);
    b = 1'($urandom);
    cfg_clk_rise = 1'b1; config_out = b; tick();
    cfg_clk_rise = 1'b0; tick();
    rda.rd_pop = 1'b1; tick(); rda.rd_pop = 1'b0; tick();
    model_pop(); model_bit(b);
    chk("simul_lvl", rda.fifo_level, 16);
    chk("simul_ovf", ov_a, 0);
    check_a("simul");
    for (int i = 0; i < 16; i++) begin
      check_a("simul_drain");
      pop_a();
    end

    // restart mid-frame
    start();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom));
    start();
    chk("restart_bc",  bc_a, 0);
    chk("restart_lvl", rda.fifo_level, 0);
    for (int i = 0; i < 32; i++) send_bit(1'($urandom));
    check_a("restart_word");

    // random bits with random pops
    start();
    for (int i = 0; i < 600; i++) begin
      send_bit(1'($urandom));
      if ($urandom_range(2) == 0) pop_a();
      check_a("rand");
    end

    // asynchronous reset mid-frame
    start();
    for (int i = 0; i < 100; i++) send_bit(1'($urandom));
    rst_n = 1'b0; #1;
    model_clear(0);
    check_a("rst_async");
    tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    check_a("rst_ignored");

    // full frame 1010..., popping as words arrive
    start();
    nwords = 0;
    for (int i = 0; i < W; i++) begin
      send_bit((i % 2) == 0);
      if (rda.rd_valid) begin
        chk("full_word", rda.rd_data, (nwords < 161) ? 32'h5555_5555 : 32'h0000_0555);
        check_a("full");
        nwords++;
        pop_a();
      end
    end
    chk("full_nwords", nwords, 162);
    chk("full_done",   fd_a, 1);
    chk("full_bc",     bc_a, W);
    chk("full_ovf",    ov_a, 0);
    check_a("full_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
